// File: rtl/ps2_rx_fifo.sv
// ============================================================================
// Module   : ps2_rx_fifo
// Purpose  : PS/2 device-to-host receiver with clock filter, frame decoder,
//            watchdog and show-ahead byte FIFO. Optional prefix folding of
//            E0/F0 into per-entry flags when PS2_RX_PREFIX_DECODE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ps2_rx_fifo #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 16,
  parameter int ADDR_W         = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              PS2_CLK,
  input  logic              PS2_DAT,
  input  logic              rd_en,
  output logic [7:0]        rd_data,
  output logic              rd_ext,
  output logic              rd_brk,
  output logic              rd_valid,
  output logic [ADDR_W:0]   fifo_count,
  output logic              parity_err,
  output logic              frame_err,
  output logic              timeout_err,
  output logic              overflow
);

`ifdef PS2_RX_PREFIX_DECODE_EN
  localparam int WORD_W = 10;
`else
  localparam int WORD_W = 8;
`endif
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  // ---------------- synchronisers and clock filter ----------------
  logic       clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic       filt_clk_q, fall_q;
  logic [7:0] filt_cnt_q;
  logic [7:0] filt_cnt_inc;
  logic       filt_toggle;

  assign filt_cnt_inc = filt_cnt_q + 8'd1;
  assign filt_toggle  = (clk_s2_q != filt_clk_q) && (filt_cnt_inc == 8'(FILTER_LEN));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      filt_clk_q <= 1'b1;
      filt_cnt_q <= 8'd0;
      fall_q     <= 1'b0;
    end else begin
      clk_s1_q <= PS2_CLK;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= PS2_DAT;
      dat_s2_q <= dat_s1_q;
      fall_q   <= filt_toggle & filt_clk_q;
      if (clk_s2_q == filt_clk_q) begin
        filt_cnt_q <= 8'd0;
      end else if (filt_toggle) begin
        filt_cnt_q <= 8'd0;
        filt_clk_q <= ~filt_clk_q;
      end else begin
        filt_cnt_q <= filt_cnt_inc;
      end
    end
  end

  // ---------------- frame decoder ----------------
  state_t            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shreg_q, shreg_d;
  logic              par_q, par_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              parity_err_d, frame_err_d, timeout_err_d, good_d;

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shreg_d       = shreg_q;
    par_d         = par_q;
    parity_err_d  = 1'b0;
    frame_err_d   = 1'b0;
    timeout_err_d = 1'b0;
    good_d        = 1'b0;
    wd_d          = (state_q == S_IDLE || fall_q) ? '0 : wd_q + WD_W'(1);

    if (state_q != S_IDLE && !fall_q && wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
      timeout_err_d = 1'b1;
      state_d       = S_IDLE;
      wd_d          = '0;
    end else if (fall_q) begin
      case (state_q)
        S_IDLE: begin
          if (!dat_s2_q) begin
            state_d   = S_DATA;
            bit_cnt_d = 3'd0;
          end
        end
        S_DATA: begin
          shreg_d   = {dat_s2_q, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          par_d   = dat_s2_q;
          state_d = S_STOP;
        end
        S_STOP: begin
          // A bad stop bit masks a parity problem in the same frame.
          if (!dat_s2_q)                   frame_err_d  = 1'b1;
          else if (!(^{shreg_q, par_q}))   parity_err_d = 1'b1;
          else                             good_d       = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // ---------------- push stage ----------------
  logic              push_q, push_d;
  logic [WORD_W-1:0] push_word_q, push_word_d;
  logic              parity_err_q, frame_err_q, timeout_err_q, overflow_q;

`ifdef PS2_RX_PREFIX_DECODE_EN
  logic ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;

  always_comb begin
    push_d      = 1'b0;
    push_word_d = '0;
    ext_pend_d  = ext_pend_q;
    brk_pend_d  = brk_pend_q;
    if (parity_err_d || frame_err_d || timeout_err_d) begin
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
    end else if (good_d) begin
      if (shreg_q == 8'hE0) begin
        ext_pend_d = 1'b1;
      end else if (shreg_q == 8'hF0) begin
        brk_pend_d = 1'b1;
      end else begin
        push_d      = 1'b1;
        push_word_d = {ext_pend_q, brk_pend_q, shreg_q};
        ext_pend_d  = 1'b0;
        brk_pend_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
    end else begin
      ext_pend_q <= ext_pend_d;
      brk_pend_q <= brk_pend_d;
    end
  end
`else
  always_comb begin
    push_d      = good_d;
    push_word_d = shreg_q;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      bit_cnt_q     <= 3'd0;
      shreg_q       <= 8'd0;
      par_q         <= 1'b0;
      wd_q          <= '0;
      push_q        <= 1'b0;
      push_word_q   <= '0;
      parity_err_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shreg_q       <= shreg_d;
      par_q         <= par_d;
      wd_q          <= wd_d;
      push_q        <= push_d;
      push_word_q   <= push_word_d;
      parity_err_q  <= parity_err_d;
      frame_err_q   <= frame_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // ---------------- show-ahead FIFO ----------------
  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [WORD_W-1:0] head_q, head_d;
  logic              do_push, do_pop, full, overflow_d;

  always_comb begin
    full       = (count_q == (ADDR_W+1)'(FIFO_DEPTH));
    do_pop     = rd_en && (count_q != '0);
    do_push    = push_q && (!full || do_pop);
    overflow_d = push_q && full && !do_pop;
    rd_ptr_d   = rd_ptr_q + ADDR_W'(do_pop);
    wr_ptr_d   = wr_ptr_q + ADDR_W'(do_push);
    count_d    = count_q + (ADDR_W+1)'(do_push) - (ADDR_W+1)'(do_pop);
    // The new head may be the word being written on this same edge.
    if (count_d == '0)                           head_d = '0;
    else if (do_push && rd_ptr_d == wr_ptr_q)    head_d = push_word_q;
    else                                         head_d = mem[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_word_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      head_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      head_q     <= head_d;
      overflow_q <= overflow_d;
    end
  end

  assign rd_data     = head_q[7:0];
  assign rd_valid    = (count_q != '0);
  assign fifo_count  = count_q;
  assign parity_err  = parity_err_q;
  assign frame_err   = frame_err_q;
  assign timeout_err = timeout_err_q;
  assign overflow    = overflow_q;
`ifdef PS2_RX_PREFIX_DECODE_EN
  assign rd_ext = head_q[9];
  assign rd_brk = head_q[8];
`else
  assign rd_ext = 1'b0;
  assign rd_brk = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
Parametrised next-generation PS/2 device-to-host receiver. It filters and synchronises PS2_CLK/PS2_DAT, decodes full 11-bit frames (start, 8 data LSB-first, odd parity, stop) with error checking and a frame watchdog, and buffers received bytes in a show-ahead FIFO. It sits between the keyboard pins and the scancode consumer, so consumers no longer need to catch a single-cycle data-enable.

Parameters:
FILTER_LEN, 8, cycles PS2_CLK must be stable before the filtered clock changes (2..255)
TIMEOUT_CYCLES, 50000, max clk cycles between filtered falling edges inside a frame
FIFO_DEPTH, 16, FIFO entries (power of two, >=2)
ADDR_W, 4, log2(FIFO_DEPTH)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
PS2_CLK  in  1  raw PS/2 clock pin
PS2_DAT  in  1  raw PS/2 data pin
rd_en  in  1  pop head entry (ignored when empty)
rd_data  out  8  head byte, valid while rd_valid=1
rd_ext  out  1  head entry had E0 prefix (optional feature)
rd_brk  out  1  head entry had F0 prefix (optional feature)
rd_valid  out  1  FIFO not empty
fifo_count  out  ADDR_W+1  entries held, 0..FIFO_DEPTH
parity_err  out  1  1-cycle pulse: parity mismatch, frame dropped
frame_err  out  1  1-cycle pulse: stop bit 0, frame dropped
timeout_err  out  1  1-cycle pulse: watchdog expired, frame dropped
overflow  out  1  1-cycle pulse: complete frame arrived with FIFO full, byte dropped

Behaviour:
- Reset: all outputs 0, FSM IDLE, FIFO empty, synchronisers and filtered clock = 1, counters 0.
- PS2_CLK and PS2_DAT each pass through 2-flop synchronisers. Filter counter increments while synced clk != filtered clk, clears otherwise; at FILTER_LEN the filtered clk toggles and the counter clears.
- fall_pulse: 1 cycle when filtered clk goes 1->0. Data sampled on fall_pulse from synced PS2_DAT.
- FSM, advancing only on fall_pulse unless noted:
  IDLE: data=0 -> DATA, bit_cnt=0; data=1 -> stay IDLE (spurious edge ignored).
  DATA: shift into shreg[7] (LSB first); after 8th bit -> PARITY.
  PARITY: capture parity bit -> STOP.
  STOP: check. Stop=0 -> frame_err. Else XOR(data,parity)=0 -> parity_err. Else push byte. Both wrong -> frame_err only. Always -> IDLE.
- Watchdog: counter clears on fall_pulse and in IDLE, increments elsewhere; at TIMEOUT_CYCLES -> timeout_err pulse, partial frame discarded, -> IDLE.
- Latency: push occurs in the cycle after the stop-bit fall_pulse; rd_valid/fifo_count update on the following edge (2 cycles after the stop-bit fall_pulse).
- FIFO: show-ahead; rd_data/rd_ext/rd_brk are registered head. Pop when rd_en && rd_valid. Push+pop same cycle: count unchanged, both performed (allowed even when full). Push when full without pop: byte dropped, overflow pulse, contents unchanged. rd_en when empty: no effect. Pointers wrap modulo FIFO_DEPTH.
- Reset mid-frame or mid-FIFO: immediate return to reset state, all contents lost.

Optional Feature:
PS2_RX_PREFIX_DECODE_EN. Defined: a pushed byte of 0xE0 sets a pending ext flag and 0xF0 sets a pending brk flag; neither is stored. The next other byte is stored with {ext,brk} in a 10-bit FIFO word, then both flags clear. Pending flags also clear on parity_err, frame_err or timeout_err. A prefix arriving with the FIFO full still only updates flags; overflow fires only when a non-prefix byte is dropped. Undefined: every byte is stored raw, FIFO is 8 bits wide, and rd_ext/rd_brk are tied 0.

Test Plan:
- Valid frame 0x1C (parity 0, stop 1), FILTER_LEN=8 -> 2 cycles after the stop fall_pulse: rd_valid=1, rd_data=0x1C, fifo_count=1, no error pulses. rd_en -> count 0.
- Frame 0x1C with parity 1 -> single parity_err pulse, fifo_count stays 0. Repeat with stop=0 -> frame_err only.
- 3-cycle low glitch on PS2_CLK while idle -> no fall_pulse, FSM stays IDLE. Then 4 data bits and PS2_CLK held high for TIMEOUT_CYCLES -> timeout_err. Then valid 0x29 -> rd_data=0x29.
- DEPTH=16: send 17 frames 0x01..0x11 with no reads -> fifo_count=16, one overflow pulse on the 17th. Reads return 0x01..0x10 in order. Simultaneous push and rd_en when full -> count stays 16, no overflow.
- Macro defined: E0, F0, 0x75 -> one entry: rd_data=0x75, rd_ext=1, rd_brk=1. Macro undefined: three entries 0xE0, 0xF0, 0x75 with ext=brk=0.
- Assert reset mid-frame after 5 bits -> all outputs 0 immediately. After release, a full 0x5A frame is received correctly.
